// File: rtl/flash_req_bridge.sv
// Upstream request stage for SPIFlashModule: one word read/write at a time on a
// valid/ready bus, level-held flash controls, idle gap between flash operations.
// Optional watchdog abort on a stuck flash_ready: define FLASH_REQ_BRIDGE_TIMEOUT_EN.
module flash_req_bridge #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        flash_en,
  output logic        flash_write,
  output logic [23:0] flash_addr,
  output logic [31:0] flash_data_in,
  input  logic [31:0] flash_data_out,
  input  logic        flash_ready,
  output logic        busy
);

  // Handshakes: a beat transfers on the rising edge where valid and ready are
  // both high; valid, once raised, holds with its payload stable until it does.
  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("flash_req_bridge: GAP_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2**25) begin : g_bad_timeout
    $error("flash_req_bridge: TIMEOUT_CYCLES out of watchdog range");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          req_ready_d, rsp_valid_d, rsp_err_d, busy_d;
  logic          flash_en_d, flash_write_d;
  logic [23:0]   flash_addr_d;
  logic [31:0]   flash_data_in_d, rsp_rdata_d;
`ifdef FLASH_REQ_BRIDGE_TIMEOUT_EN
  logic [24:0]   wd_q, wd_d;
`endif

  always_comb begin
    state_d         = state_q;
    gap_d           = gap_q;
    req_ready_d     = req_ready;
    rsp_valid_d     = rsp_valid;
    rsp_rdata_d     = rsp_rdata;
    rsp_err_d       = rsp_err;
    flash_en_d      = flash_en;
    flash_write_d   = flash_write;
    flash_addr_d    = flash_addr;
    flash_data_in_d = flash_data_in;
`ifdef FLASH_REQ_BRIDGE_TIMEOUT_EN
    wd_d            = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error without touching the flash.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
            state_d     = RESP;
          end else begin
            flash_en_d      = 1'b1;
            flash_write_d   = req_write;
            flash_addr_d    = req_addr;
            flash_data_in_d = req_wdata;
            state_d         = WAIT;
`ifdef FLASH_REQ_BRIDGE_TIMEOUT_EN
            wd_d            = 25'd0;
`endif
          end
        end
      end
      WAIT: begin
        if (flash_ready) begin
          rsp_rdata_d   = flash_write ? 32'd0 : flash_data_out;
          rsp_err_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          flash_en_d    = 1'b0;
          flash_write_d = 1'b0;
          state_d       = RESP;
        end
`ifdef FLASH_REQ_BRIDGE_TIMEOUT_EN
        else if (wd_q == 25'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d   = 32'd0;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = 1'b1;
          flash_en_d    = 1'b0;
          flash_write_d = 1'b0;
          state_d       = RESP;
        end else begin
          wd_d = wd_q + 25'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          gap_d       = GW'(GAP_CYCLES - 1);
          state_d     = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = GAP;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q       <= GAP;
      gap_q         <= GW'(GAP_CYCLES);
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_err       <= 1'b0;
      flash_en      <= 1'b0;
      flash_write   <= 1'b0;
      flash_addr    <= 24'd0;
      flash_data_in <= 32'd0;
      busy          <= 1'b0;
`ifdef FLASH_REQ_BRIDGE_TIMEOUT_EN
      wd_q          <= 25'd0;
`endif
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_err       <= rsp_err_d;
      flash_en      <= flash_en_d;
      flash_write   <= flash_write_d;
      flash_addr    <= flash_addr_d;
      flash_data_in <= flash_data_in_d;
      busy          <= busy_d;
`ifdef FLASH_REQ_BRIDGE_TIMEOUT_EN
      wd_q          <= wd_d;
`endif
    end
  end

endmodule
